// File: rtl/sw_submit_capture_pkg.sv
// Shared game constants: pattern type, idle code, capture FSM encoding, debounce length.
// Used by the capture block, the level/sequence stage and the display logic.
package sw_submit_capture_pkg;

  typedef logic [3:0] pattern_t;

  localparam pattern_t PATTERN_IDLE          = 4'b1111;
  localparam int       NUM_SW                = 4;
  localparam int       DEBOUNCE_CYCLES_25MHZ = 250_000;
  localparam int       SYNC_STAGES_DEFAULT   = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_PENDING = 3'd2;
  localparam logic [2:0] ST_FIRE    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

endpackage

// File: rtl/sw_submit_capture_debounce_bit.sv
// Synchroniser plus stability counter for one raw asynchronous bit.
// Level follows raw input SYNC_STAGES+DEBOUNCE_CYCLES cycles after it settles; no backpressure.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic stable_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Counter parks at DEBOUNCE_CYCLES once the input has been judged stable.
  localparam logic [CW-1:0] CNT_STOP = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   prev_q;
  logic                   level_q, level_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_bit != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = CNT_STOP;
      level_d = sync_bit;
    end else if (cnt_q != CNT_STOP) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= CNT_STOP;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      prev_q  <= sync_bit;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o  = level_q;
  assign stable_o = (cnt_q == CNT_STOP);

endmodule

// File: rtl/sw_submit_capture.sv
// Debounced switch/button capture: one single-cycle pattern (or reject) pulse per clean press.
// change appears SYNC_STAGES+DEBOUNCE_CYCLES+2 cycles after a clean press; no backpressure.
module sw_submit_capture
  import sw_submit_capture_pkg::*;
#(
  parameter int       DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25MHZ,
  parameter int       SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter pattern_t IDLE_CODE       = PATTERN_IDLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] change,
  output logic       rejected,
  output logic       armed
);

  localparam int            NB          = NUM_SW + 1;
  localparam int            SETW        = $clog2(SYNC_STAGES + 2);
  localparam logic [SETW-1:0] SETTLE_LAST = SETW'(SYNC_STAGES + 1);

  logic [NB-1:0] raw_vec;
  logic [NB-1:0] lvl;
  logic [NB-1:0] stb;

  assign raw_vec = {btn, sw};

  for (genvar i = 0; i < NB; i++) begin : g_deb
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw_vec[i]),
      .level_o (lvl[i]),
      .stable_o(stb[i])
    );
  end

  pattern_t sw_lvl;
  logic     btn_lvl, btn_stable, sw_stable_all, btn_rise, settle_done;

  logic [2:0]      state_q, state_d;
  logic            btn_prev_q;
  logic [SETW-1:0] settle_q;
  pattern_t        change_q, change_d;
  logic            rejected_q, rejected_d;
  logic            armed_q;

  assign sw_lvl        = lvl[NUM_SW-1:0];
  assign btn_lvl       = lvl[NUM_SW];
  assign btn_stable    = stb[NUM_SW];
  assign sw_stable_all = &stb[NUM_SW-1:0];
  assign btn_rise      = btn_lvl & ~btn_prev_q;
  assign settle_done   = (settle_q == SETTLE_LAST);

  // IDLE waits for the synchronisers to flush and the button to settle, so a
  // button held through reset is seen as held (HOLD) rather than as a new press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (settle_done && btn_stable) state_d = btn_lvl ? ST_HOLD : ST_ARMED;
      ST_ARMED:   if (btn_rise) state_d = sw_stable_all ? ST_FIRE : ST_PENDING;
      ST_PENDING: begin
        if (!btn_lvl)          state_d = ST_ARMED;
        else if (sw_stable_all) state_d = ST_FIRE;
      end
      ST_FIRE:    state_d = ST_HOLD;
      ST_HOLD:    if (!btn_lvl) state_d = ST_ARMED;
      default:    state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  always_comb begin
    change_d   = IDLE_CODE;
    rejected_d = 1'b0;
    if (state_q == ST_FIRE && enable) begin
      if (sw_lvl == IDLE_CODE) rejected_d = 1'b1;
      else                     change_d   = sw_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      btn_prev_q <= 1'b0;
      settle_q   <= '0;
      change_q   <= IDLE_CODE;
      rejected_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_lvl;
      if (!settle_done) settle_q <= settle_q + SETW'(1);
      change_q   <= change_d;
      rejected_q <= rejected_d;
      armed_q    <= (state_d == ST_ARMED);
    end
  end

  assign change   = change_q;
  assign rejected = rejected_q;
  assign armed    = armed_q;

endmodule
